// File: rtl/falling_object_mover.sv
// -----------------------------------------------------------------------------
// falling_object_mover
//   Moves N_OBJ independent road pickups/obstacles down the screen. Each channel
//   has a fixed-point Y position and speed. On every frame it advances by its
//   own speed plus the shared road scroll, then accelerates up to a ceiling.
//   A channel is retired when the collision logic reports a pickup (collected)
//   or when it drops below the bottom of the screen (failed).
//
// Ports
//   clk, resetN    system clock, asynchronous active-low reset
//   startOfFrame   one-cycle pulse per video frame
//   freeze         1 = frame pulses ignored, objects hold position and speed
//   scroll_speed   unsigned fixed-point Y offset added every frame
//   spawn          per-channel spawn request pulse
//   spawn_x        per-channel spawn X in pixels, channel i at [11*i +: 11]
//   hit            per-channel pickup/collision pulse
//   topLeftX/Y     signed pixel position per channel, packed like spawn_x
//   active         channel is on screen and should be drawn
//   collected      one-cycle pulse: hit accepted on an active channel
//   failed         one-cycle pulse: active channel passed the bottom edge
// -----------------------------------------------------------------------------
module falling_object_mover #(
  parameter int N_OBJ        = 4,
  parameter int FRAC_BITS    = 6,
  parameter int POS_W        = 18,
  parameter int INITIAL_Y    = -32,
  parameter int INIT_Y_SPEED = 20,
  parameter int Y_ACCEL      = 5,
  parameter int MAX_Y_SPEED  = 400,
  parameter int BOTTOM_Y     = 479
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 freeze,
  input  logic [7:0]           scroll_speed,
  input  logic [N_OBJ-1:0]     spawn,
  input  logic [N_OBJ*11-1:0]  spawn_x,
  input  logic [N_OBJ-1:0]     hit,
  output logic [N_OBJ*11-1:0]  topLeftX,
  output logic [N_OBJ*11-1:0]  topLeftY,
  output logic [N_OBJ-1:0]     active,
  output logic [N_OBJ-1:0]     collected,
  output logic [N_OBJ-1:0]     failed
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    MOVE,
    POS_CHANGE,
    POS_LIMITS
  } state_t;

  localparam logic signed [POS_W-1:0] Y_SPAWN     = POS_W'(INITIAL_Y * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] SPEED_SPAWN = POS_W'(INIT_Y_SPEED);
  localparam logic signed [POS_W-1:0] ACCEL       = POS_W'(Y_ACCEL);
  localparam logic signed [POS_W-1:0] SPEED_MAX   = POS_W'(MAX_Y_SPEED);
  localparam logic signed [POS_W-1:0] Y_BOTTOM    = POS_W'(BOTTOM_Y);

  // Scroll is an unsigned magnitude, so it is zero-extended before the signed add.
  logic signed [POS_W-1:0] scroll_ext;
  assign scroll_ext = {{(POS_W-8){1'b0}}, scroll_speed};

  logic frame_tick;
  assign frame_tick = startOfFrame && !freeze;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_ch
    state_t                  state, state_nxt;
    // X never moves after spawn, so only its pixel part is kept.
    logic [10:0]             xpix, xpix_nxt;
    logic signed [POS_W-1:0] ypos, ypos_nxt;
    logic signed [POS_W-1:0] yspd, yspd_nxt;
    logic signed [POS_W-1:0] y_sum, spd_acc, y_px;
    logic                    col, fail;

    assign y_sum   = ypos + yspd + scroll_ext;
    assign spd_acc = yspd + ACCEL;
    // Arithmetic shift floors negative positions (object partly above the screen).
    assign y_px    = ypos >>> FRAC_BITS;

    always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case leaves one unassigned and no latch is inferred.
      state_nxt = state;
      xpix_nxt  = xpix;
      ypos_nxt  = ypos;
      yspd_nxt  = yspd;
      col       = 1'b0;
      fail      = 1'b0;

      if (state == IDLE) begin
        if (spawn[g]) begin
          xpix_nxt  = spawn_x[11*g +: 11];
          ypos_nxt  = Y_SPAWN;
          yspd_nxt  = SPEED_SPAWN;
          state_nxt = ARMED;
        end
      end else if (hit[g]) begin
        // A pickup overrides the frame step, the position update and a miss.
        col       = 1'b1;
        state_nxt = IDLE;
      end else begin
        case (state)
          ARMED: if (frame_tick) state_nxt = MOVE;
          MOVE:  if (frame_tick) state_nxt = POS_CHANGE;
          POS_CHANGE: begin
            ypos_nxt  = y_sum;
            yspd_nxt  = (spd_acc <= SPEED_MAX) ? spd_acc : SPEED_MAX;
            state_nxt = POS_LIMITS;
          end
          POS_LIMITS: begin
            if (y_px > Y_BOTTOM) begin
              fail      = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = MOVE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge resetN) begin
      // NOTE: state registers use non-blocking assignments so every channel
      // samples the same pre-edge values regardless of statement order.
      if (!resetN) begin
        state <= IDLE;
        xpix  <= '0;
        ypos  <= '0;
        yspd  <= '0;
      end else begin
        state <= state_nxt;
        xpix  <= xpix_nxt;
        ypos  <= ypos_nxt;
        yspd  <= yspd_nxt;
      end
    end

    assign topLeftX[11*g +: 11] = xpix;
    assign topLeftY[11*g +: 11] = y_px[10:0];
    assign active[g]            = (state != IDLE);
    assign collected[g]         = col;
    assign failed[g]            = fail;
  end

endmodule

// File: tb/tb_falling_object_mover.sv
// -----------------------------------------------------------------------------
// tb_falling_object_mover
//   Self-checking bench for falling_object_mover. A small integer reference
//   model predicts every output each cycle; predictions are queued when the
//   inputs are driven and compared when the outputs are sampled mid-cycle.
//   A table of vectors pins down the first frames of a spawn, and hand-written
//   sequences cover saturation, misses, pickups, freeze and async reset.
// -----------------------------------------------------------------------------
module tb_falling_object_mover;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             resetN;
  logic             sof;
  logic             freeze;
  logic [7:0]       scroll;
  logic [N-1:0]     spawn;
  logic [N*11-1:0]  spawn_x;
  logic [N-1:0]     hit;
  logic [N*11-1:0]  tlx, tly;
  logic [N-1:0]     act, col, fail;

  falling_object_mover dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
    .freeze       (freeze),
    .scroll_speed (scroll),
    .spawn        (spawn),
    .spawn_x      (spawn_x),
    .hit          (hit),
    .topLeftX     (tlx),
    .topLeftY     (tly),
    .active       (act),
    .collected    (col),
    .failed       (fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [43:0] x;
    logic [43:0] y;
    logic [3:0]  act;
    logic [3:0]  col;
    logic [3:0]  fail;
  } out_t;

  typedef struct packed {
    logic        spawn0;
    logic        sof;
    logic        act0;
    logic [10:0] x0;
    logic [10:0] y0;
  } vec_t;

  out_t exp_q[$];
  out_t s_out = '0;
  out_t prev_out = '0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  int   fail_cnt[N];
  int   m_st[N], m_x[N], m_y[N], m_s[N];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cycle, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_s[i] = 0;
    end
  endtask

  // Expected outputs for the current cycle, given model state and driven inputs.
  function automatic out_t model_out();
    out_t        o;
    logic [31:0] v;
    o = '0;
    for (int i = 0; i < N; i++) begin
      v = m_x[i] >>> 6;
      o.x[11*i +: 11] = v[10:0];
      v = m_y[i] >>> 6;
      o.y[11*i +: 11] = v[10:0];
      o.act[i]  = (m_st[i] != 0);
      o.col[i]  = (m_st[i] != 0) && hit[i];
      o.fail[i] = (m_st[i] == 4) && !hit[i] && ((m_y[i] >>> 6) > 479);
    end
    return o;
  endfunction

  // Model update at the clock edge. States: 0 idle, 1 armed, 2 move, 3 change, 4 limits.
  task automatic model_step();
    if (!resetN) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 0) begin
        if (spawn[i]) begin
          m_x[i]  = $signed(spawn_x[11*i +: 11]) * 64;
          m_y[i]  = -32 * 64;
          m_s[i]  = 20;
          m_st[i] = 1;
        end
      end else if (hit[i]) begin
        m_st[i] = 0;
      end else begin
        case (m_st[i])
          1: if (sof && !freeze) m_st[i] = 2;
          2: if (sof && !freeze) m_st[i] = 3;
          3: begin
            m_y[i] += m_s[i] + int'(scroll);
            m_s[i]  = (m_s[i] + 5 > 400) ? 400 : m_s[i] + 5;
            m_st[i] = 4;
          end
          4: m_st[i] = ((m_y[i] >>> 6) > 479) ? 0 : 2;
          default: m_st[i] = 0;
        endcase
      end
    end
  endtask

  // One clock cycle: queue the prediction, compare at the falling edge, advance.
  task automatic step();
    out_t e;
    exp_q.push_back(model_out());
    @(negedge clk);
    prev_out = s_out;
    s_out    = {tlx, tly, act, col, fail};
    e        = exp_q.pop_front();
    check("scoreboard", s_out, e);
    for (int i = 0; i < N; i++) begin
      fail_cnt[i] += int'(s_out.fail[i]);
      if (prev_out.fail[i])
        check($sformatf("active_after_fail_ch%0d", i), s_out.act[i], 1'b0);
    end
    @(posedge clk);
    model_step();
    cycle++;
    #1;
  endtask

  task automatic frame();
    sof = 1'b1;
    step();
    sof = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[13];
    logic [10:0] ym32, ym31, y2_snap;
    logic [43:0] y_snap;
    int          ya, yb, k;

    ym32 = 11'h7E0;
    ym31 = 11'h7E1;
    //          spawn0 sof  act0  x0       y0
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 11'd0,   11'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 11'd100, ym32};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 11'd100, ym32};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 11'd100, ym32};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 11'd100, ym32};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 11'd100, ym32};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 11'd100, ym32};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 11'd100, ym32};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 11'd100, ym32};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 11'd100, ym32};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 11'd100, ym32};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 11'd100, ym32};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 11'd100, ym31};

    resetN = 1'b0; sof = 1'b0; freeze = 1'b0; scroll = 8'd0;
    spawn = '0; hit = '0; spawn_x = '0;
    model_reset();
    for (int i = 0; i < N; i++) fail_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {tlx, tly, act, col, fail}, '0);
    resetN = 1'b1;

    // First frames after a spawn: armed hold, two-cycle latency, floor of negative Y.
    spawn_x[10:0] = 11'd100;
    for (int r = 0; r < 13; r++) begin
      spawn[0] = tbl[r].spawn0;
      sof      = tbl[r].sof;
      step();
      check($sformatf("vec_r%0d", r), {s_out.act[0], s_out.x[10:0], s_out.y[10:0]},
            {tbl[r].act0, tbl[r].x0, tbl[r].y0});
    end
    spawn = '0;
    sof   = 1'b0;

    // Speed saturation on ch0: once at 400, eight frames move exactly 3200 units = 50 px.
    spawn_x[21:11] = 11'd300;
    spawn[1] = 1'b1;
    step();
    spawn = '0;
    k = 0;
    while (m_s[0] < 400 && k < 200) begin
      frame();
      k++;
    end
    frame();
    ya = $signed(s_out.y[10:0]);
    repeat (8) frame();
    yb = $signed(s_out.y[10:0]);
    check("sat_delta_8_frames", yb - ya, 50);

    // Run ch1 (and ch0) off the bottom with scroll; ch3 spawned late stays up.
    scroll = 8'd40;
    spawn_x[43:33] = 11'd600;
    spawn[3] = 1'b1;
    step();
    spawn = '0;
    k = 0;
    while (fail_cnt[1] == 0 && k < 300) begin
      frame();
      k++;
    end
    check("ch1_single_fail", fail_cnt[1], 1);
    check("ch0_single_fail", fail_cnt[0], 1);
    check("ch1_inactive", s_out.act[1], 1'b0);
    check("ch3_still_active", s_out.act[3], 1'b1);

    // Pickup on ch2 in the same cycle as a frame pulse; hit on idle ch0 ignored.
    spawn_x[32:22] = 11'd50;
    spawn[2] = 1'b1;
    step();
    spawn = '0;
    repeat (3) frame();
    y2_snap = s_out.y[32:22];
    hit = 4'b0101;
    sof = 1'b1;
    step();
    check("collected_ch2", s_out.col[2], 1'b1);
    check("no_fail_ch2", s_out.fail[2], 1'b0);
    check("hit_idle_ignored_ch0", s_out.col[0], 1'b0);
    hit = '0;
    sof = 1'b0;
    step();
    check("ch2_inactive", s_out.act[2], 1'b0);
    check("ch2_y_not_updated", s_out.y[32:22], y2_snap);
    check("collected_single_pulse", s_out.col[2], 1'b0);
    repeat (5) step();

    // Freeze: frame pulses ignored, spawn still acts; release resumes motion.
    freeze = 1'b1;
    spawn_x[10:0] = 11'd20;
    spawn[0] = 1'b1;
    step();
    spawn = '0;
    step();
    y_snap = s_out.y;
    repeat (5) frame();
    check("freeze_y_hold", s_out.y, y_snap);
    check("freeze_spawn_active", s_out.act[0], 1'b1);
    freeze = 1'b0;
    repeat (2) frame();
    check("resume_ch3_moved", s_out.y[43:33] != y_snap[43:33], 1'b1);

    // Asynchronous reset mid-frame, then a fresh spawn.
    spawn_x[21:11] = 11'd111;
    spawn_x[32:22] = 11'd222;
    spawn = 4'b0110;
    step();
    spawn = '0;
    frame();
    sof = 1'b1;
    step();
    sof = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    check("async_reset_outputs", {tlx, tly, act, col, fail}, '0);
    model_reset();
    repeat (2) step();
    resetN = 1'b1;
    spawn_x[10:0] = 11'd7;
    spawn[0] = 1'b1;
    step();
    spawn = '0;
    step();
    check("respawn_active", s_out.act[0], 1'b1);
    check("respawn_x", s_out.x[10:0], 11'd7);
    check("respawn_others_idle", s_out.act[3:1], 3'b000);
    repeat (3) frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
